// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parameterised UART receiver.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
package uart_rx_param_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Parity modes, matching the PARITY parameter encoding
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per oversample tick; integer division floors, clamped to 1
  function automatic int calc_div(input int clk_freq, input int tick_rate);
    int div;
    div = clk_freq / tick_rate;
    if (div < 1) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_param_baud_rate_gen.sv
// Oversample tick generator: one-cycle pulse every calc_div(CLK_FREQ, BAUD_RATE) cycles.
// Latency: first tick DIV cycles after reset release.
// Backpressure: none; i_valid low freezes the divider.
import uart_rx_param_pkg::*;

module baud_rate_gen #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 153600
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_valid,
  output logic o_tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Divider counter wraps at DIV-1 and emits a registered tick on the wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= 1'b0;
      if (i_valid) begin
        if (cnt == CW'(DIV - 1)) begin
          cnt    <= '0;
          o_tick <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with optional parity, 1/2 stop bits and a held-frame output register.
// Latency: frame delivered one cycle after the last stop-bit sample (mid stop bit).
// Backpressure: o_valid/i_ready; an unconsumed frame is overwritten and flagged with o_overrun.
import uart_rx_param_pkg::*;

module uart_rx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_rx_done,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  // Tick counter tops out at OVERSAMPLE-1, bit counter at DATA_BITS-1
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_CNT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 tick;
  rx_state_t            state;
  logic                 armed;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err;
  logic                 frm_err;
  logic                 done_pend;

  baud_rate_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE * OVERSAMPLE)
  ) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_valid(1'b1),
    .o_tick (tick)
  );

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  // Frame FSM on tick cycles plus the held-frame output register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      done_pend    <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_rx_done    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      done_pend <= 1'b0;
      o_rx_done <= 1'b0;

      // Completion wins over a same-cycle handshake: new frame stays valid
      if (done_pend) begin
        o_data       <= shift;
        o_parity_err <= par_err;
        o_frame_err  <= frm_err;
        o_rx_done    <= 1'b1;
        o_valid      <= 1'b1;
        o_overrun    <= o_valid && !i_ready;
      end else if (o_valid && i_ready) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end

      if (tick) begin
        if (rx_sync) armed <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (armed && !rx_sync) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == HALF_CNT) begin
              tick_cnt <= '0;
              if (!rx_sync) begin
                state   <= ST_DATA;
                bit_cnt <= '0;
                par_err <= 1'b0;
                frm_err <= 1'b0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_DATA: begin
            if (tick_cnt == LAST_CNT) begin
              tick_cnt <= '0;
              shift    <= {rx_sync, shift[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_PARITY: begin
            if (tick_cnt == LAST_CNT) begin
              tick_cnt <= '0;
              par_err  <= (PARITY == PAR_ODD) ? ~(^shift ^ rx_sync) : (^shift ^ rx_sync);
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_STOP: begin
            if (tick_cnt == LAST_CNT) begin
              tick_cnt <= '0;
              if (!rx_sync) frm_err <= 1'b1;
              if (bit_cnt == LAST_STOP) begin
                bit_cnt   <= '0;
                state     <= ST_IDLE;
                done_pend <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // A completed frame must see the line high again before the next start
      if (done_pend) armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 8N2) at DIV=10, 160 cycles per bit.
// Latency: expected frames are queued when sent and matched on each o_rx_done pulse.
// Backpressure: i_ready driven per instance; held-frame valid/overrun tracked by the model.
import uart_rx_param_pkg::*;

module tb_uart_rx_param;

  localparam int BIT_CYC = 160;

  typedef struct {
    int         k;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i  [3];
  logic       rdy_i [3];
  logic       rdy_e [3];
  logic [7:0] data_o[3];
  logic       vld_o [3];
  logic       done_o[3];
  logic       perr_o[3];
  logic       ferr_o[3];
  logic       ovr_o [3];

  bit         mvalid[3];
  bit         movr  [3];
  bit         mperr [3];
  bit         mferr [3];
  logic [7:0] mdata [3];
  exp_t       exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .i_clk(clk), .i_reset(rst), .i_rx(rx_i[0]), .i_ready(rdy_i[0]),
    .o_data(data_o[0]), .o_valid(vld_o[0]), .o_rx_done(done_o[0]),
    .o_parity_err(perr_o[0]), .o_frame_err(ferr_o[0]), .o_overrun(ovr_o[0]));

  uart_rx_param #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
    .i_clk(clk), .i_reset(rst), .i_rx(rx_i[1]), .i_ready(rdy_i[1]),
    .o_data(data_o[1]), .o_valid(vld_o[1]), .o_rx_done(done_o[1]),
    .o_parity_err(perr_o[1]), .o_frame_err(ferr_o[1]), .o_overrun(ovr_o[1]));

  uart_rx_param #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .i_clk(clk), .i_reset(rst), .i_rx(rx_i[2]), .i_ready(rdy_i[2]),
    .o_data(data_o[2]), .o_valid(vld_o[2]), .o_rx_done(done_o[2]),
    .o_parity_err(perr_o[2]), .o_frame_err(ferr_o[2]), .o_overrun(ovr_o[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Ready as seen by the DUT at each rising edge
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) rdy_e[k] <= rdy_i[k];
  end

  // Model of the held frame: every cycle compare valid/overrun/held fields
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mvalid[k] = 1'b0; movr[k] = 1'b0; mperr[k] = 1'b0; mferr[k] = 1'b0; mdata[k] = 8'h00;
        chk($sformatf("rst_done%0d", k), 32'(done_o[k]), 32'd0);
      end else if (done_o[k]) begin
        if (exp_q.size() == 0 || exp_q[0].k != k) begin
          chk($sformatf("unexpected_done%0d", k), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          movr[k]   = mvalid[k] && !rdy_e[k];
          mvalid[k] = 1'b1;
          mdata[k]  = e.data;
          mperr[k]  = e.perr;
          mferr[k]  = e.ferr;
        end
      end else if (mvalid[k] && rdy_e[k]) begin
        mvalid[k] = 1'b0;
        movr[k]   = 1'b0;
      end
      chk($sformatf("valid%0d", k),   32'(vld_o[k]),  32'(mvalid[k]));
      chk($sformatf("overrun%0d", k), 32'(ovr_o[k]),  32'(movr[k]));
      chk($sformatf("data%0d", k),    32'(data_o[k]), 32'(mdata[k]));
      chk($sformatf("perr%0d", k),    32'(perr_o[k]), 32'(mperr[k]));
      chk($sformatf("ferr%0d", k),    32'(ferr_o[k]), 32'(mferr[k]));
    end
  end

  // Advance n rising edges, then settle 3 time units past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drive_bit(input int k, input logic b);
    rx_i[k] = b;
    cyc(BIT_CYC);
  endtask

  // Send one frame on line k and queue what the receiver must report for it
  task automatic send(input int k, input logic [7:0] d, input bit has_p, input logic p,
                      input logic s1, input logic s2, input int nstop);
    exp_t e;
    e.k    = k;
    e.data = d;
    e.perr = has_p ? ((^d) ^ p) : 1'b0;
    e.ferr = !s1 || (nstop == 2 && !s2);
    exp_q.push_back(e);
    drive_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
    if (has_p) drive_bit(k, p);
    drive_bit(k, s1);
    if (nstop == 2) drive_bit(k, s2);
    drive_bit(k, 1'b1);
    drive_bit(k, 1'b1);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rx_i[k]  = 1'b1;
      rdy_i[k] = 1'b1;
      rdy_e[k] = 1'b1;
    end
    cyc(5);
    chk("reset_data", 32'(data_o[0]), 32'h0);
    chk("reset_valid", 32'(vld_o[0]), 32'h0);
    rst = 1'b0;
    cyc(2 * BIT_CYC);

    // 8N1 basic frame
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    chk("n1_a5_data", 32'(data_o[0]), 32'hA5);
    chk("n1_a5_perr", 32'(perr_o[0]), 32'h0);
    chk("n1_a5_ferr", 32'(ferr_o[0]), 32'h0);

    // 8E1 parity checks
    send(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    chk("e1_3c_data", 32'(data_o[1]), 32'h3C);
    chk("e1_3c_p1_perr", 32'(perr_o[1]), 32'h1);
    send(1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    chk("e1_3c_p0_perr", 32'(perr_o[1]), 32'h0);

    // 8N2: good frame, then second stop bit low
    send(2, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    chk("n2_good_ferr", 32'(ferr_o[2]), 32'h0);
    send(2, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    chk("n2_stop2_ferr", 32'(ferr_o[2]), 32'h1);
    chk("n2_stop2_data", 32'(data_o[2]), 32'h55);

    // Overrun with consumer stalled, then a single ready pulse
    rdy_i[0] = 1'b0;
    send(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    chk("ovr_data", 32'(data_o[0]), 32'h22);
    chk("ovr_flag", 32'(ovr_o[0]), 32'h1);
    chk("ovr_valid", 32'(vld_o[0]), 32'h1);
    rdy_i[0] = 1'b1;
    cyc(1);
    rdy_i[0] = 1'b0;
    cyc(2);
    chk("ack_valid", 32'(vld_o[0]), 32'h0);
    chk("ack_ovr", 32'(ovr_o[0]), 32'h0);
    rdy_i[0] = 1'b1;

    // 40-cycle glitch must be rejected, then a real frame
    rx_i[0] = 1'b0;
    cyc(40);
    rx_i[0] = 1'b1;
    cyc(200);
    chk("glitch_idle", 32'(u_n1.state == ST_IDLE), 32'h1);
    send(0, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    chk("after_glitch_data", 32'(data_o[0]), 32'h7E);

    // Break: one frame of zeros with a frame error, no restart while low
    e.k = 0; e.data = 8'h00; e.perr = 1'b0; e.ferr = 1'b1;
    exp_q.push_back(e);
    rx_i[0] = 1'b0;
    cyc(14 * BIT_CYC);
    chk("break_data", 32'(data_o[0]), 32'h0);
    chk("break_ferr", 32'(ferr_o[0]), 32'h1);
    chk("break_idle", 32'(u_n1.state == ST_IDLE), 32'h1);
    rx_i[0] = 1'b1;
    cyc(2 * BIT_CYC);

    // Reset in bit 3 of 0xF0 with the line held low through release
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
    cyc(BIT_CYC / 2);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("midreset_data", 32'(data_o[0]), 32'h0);
    chk("midreset_done", 32'(done_o[0]), 32'h0);
    cyc(400);
    chk("midreset_idle", 32'(u_n1.state == ST_IDLE), 32'h1);
    rx_i[0] = 1'b1;
    cyc(2 * BIT_CYC);
    send(0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    chk("after_reset_data", 32'(data_o[0]), 32'h0F);

    chk("all_frames_seen", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line rate in bit/s.
REQ-003 Parameter OVERSAMPLE, default 16, ticks per bit; legal values are even and at least 8.
REQ-004 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-005 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 Parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-007 i_clk  in  1  single system clock; all logic on its rising edge.
REQ-008 i_reset  in  1  reset, asynchronous, active-high.
REQ-009 i_rx  in  1  asynchronous serial input; idles high.
REQ-010 i_ready  in  1  consumer accepts the held frame when high while o_valid is high.
REQ-011 o_data  out  DATA_BITS  last received payload, LSB received first.
REQ-012 o_valid  out  1  held frame is unconsumed.
REQ-013 o_rx_done  out  1  one-cycle pulse per completed frame.
REQ-014 o_parity_err  out  1  parity mismatch on the held frame; 0 when PARITY=0.
REQ-015 o_frame_err  out  1  some stop-bit sample was low on the held frame.
REQ-016 o_overrun  out  1  the held frame replaced an unconsumed frame.

Function
REQ-017 i_rx shall pass through a 2-flop synchroniser; flops reset to 1.
REQ-018 The internal tick shall be a 1-cycle pulse every DIV = floor(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)) cycles (50 MHz/9600/16 -> DIV=325).
REQ-019 The FSM states shall be IDLE, START, DATA, PARITY, STOP; all sampling and counting occurs only on tick cycles.
REQ-020 IDLE: the synchronised line seen low on a tick while the "armed" flag is set -> START, tick counter cleared; "armed" is set by any tick-sampled high and cleared on reset and on frame completion.
REQ-021 START: at tick count OVERSAMPLE/2-1, a low line -> DATA with counter cleared; a high line (glitch) -> IDLE with no outputs changed.
REQ-022 DATA: on each tick count OVERSAMPLE-1, sample one bit and shift it in LSB first; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: sample one bit at count OVERSAMPLE-1; error for odd mode if the XOR of data and parity is 0, for even mode if it is 1.
REQ-024 STOP: sample STOP_BITS bits at count OVERSAMPLE-1 each; any low sample sets the frame error; after the last sample -> IDLE.
REQ-025 Completion: in the cycle after the final stop sample, load o_data, o_parity_err and o_frame_err, pulse o_rx_done for exactly one cycle, and set o_valid.
REQ-026 Handshake: o_valid && i_ready clears o_valid and o_overrun on the next edge; the held outputs stay stable while o_valid is high.
REQ-027 Completion with o_valid=1 and i_ready=0 shall overwrite the held frame and set o_overrun=1.
REQ-028 Completion coincident with o_valid && i_ready shall load the new frame, keep o_valid=1 and set o_overrun=0.
REQ-029 A frame with a frame error shall still be delivered; a line held low (break) shall yield o_data=0 with o_frame_err=1, then no new start until the line is seen high.
REQ-030 Tick and bit counters shall be sized by $clog2 of their maximum and shall never exceed it.

Reset
REQ-031 On i_reset: FSM=IDLE, armed=0, counters=0, shift register=0, all outputs 0, synchroniser=1.
REQ-032 Reset mid-frame shall abandon the frame with no o_rx_done; after release, a line already low shall not be taken as a start.

Structure
REQ-033 A shared package shall hold the state enumeration, the parity-mode constants (NONE/ODD/EVEN) and the DIV computation function.
REQ-034 One sub-module, baud_rate_gen (parameters CLK_FREQ, BAUD_RATE*OVERSAMPLE; i_valid tied high), shall generate the tick; the FSM and output register stay in uart_rx_param.

Verification (CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16 -> DIV=10, 160 cycles/bit)
REQ-035 8N1, send 0xA5 -> o_data=0xA5, one o_rx_done pulse, o_valid=1, all error flags 0.
REQ-036 8E1, send 0x3C with parity bit 1 -> o_data=0x3C, o_parity_err=1; repeat with parity bit 0 -> o_parity_err=0.
REQ-037 STOP_BITS=2, send 0x55 with second stop bit low -> o_frame_err=1, o_data=0x55.
REQ-038 i_ready=0, send 0x11 then 0x22 -> o_data=0x22, o_overrun=1; i_ready pulse -> o_valid=0, o_overrun=0.
REQ-039 Low glitch of 40 cycles on an idle line -> no o_rx_done and FSM back in IDLE; then send 0x7E -> 0x7E received.
REQ-040 Assert i_reset during bit 3 of 0xF0 while holding the line low through release -> no o_rx_done; the next 0x0F sent is received correctly.
